// File: rtl/pulse_width_monitor.sv
// rtl/pulse_width_monitor.sv - synchronizes a level, detects edges and measures high/low interval widths
module pulse_width_monitor #(
  parameter int CNT_W       = 16,
  parameter int EDGE_CNT_W  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  D,
  input  logic                  clr,
  output logic                  Q,
  output logic                  rise,
  output logic                  fall,
  output logic [CNT_W-1:0]      high_width,
  output logic [CNT_W-1:0]      low_width,
  output logic                  width_valid,
  output logic [EDGE_CNT_W-1:0] edge_count,
  output logic                  ovf
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   q_d;
  state_t                 state;
  state_t                 state_next;
  logic                   cap_high;
  logic                   cap_low;
  logic [CNT_W-1:0]       run_cnt;
  logic                   edge_seen;
  logic                   counting;

  // clr deliberately leaves the synchronizer alone so edges keep pulsing
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], D};
      q_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign Q         = sync[SYNC_STAGES-1];
  assign rise      = Q & ~q_d;
  assign fall      = ~Q & q_d;
  assign edge_seen = rise | fall;
  assign counting  = (state != IDLE);

  always_comb begin
    state_next = state;
    cap_high   = 1'b0;
    cap_low    = 1'b0;
    case (state)
      IDLE: begin
        if (rise)      state_next = HIGH;
        else if (fall) state_next = LOW;
      end
      HIGH: begin
        if (fall) begin
          cap_high   = 1'b1;
          state_next = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          cap_low    = 1'b1;
          state_next = HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
    // a clear that lands on an edge discards that edge entirely
    if (clr) begin
      state_next = IDLE;
      cap_high   = 1'b0;
      cap_low    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state       <= IDLE;
      run_cnt     <= '0;
      high_width  <= '0;
      low_width   <= '0;
      width_valid <= 1'b0;
      edge_count  <= '0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_next;
      width_valid <= cap_high | cap_low;
      if (cap_high) high_width <= run_cnt;
      if (cap_low)  low_width  <= run_cnt;
      if (edge_seen) begin
        run_cnt <= CNT_W'(1);
      end else if (counting) begin
        if (&run_cnt) ovf <= 1'b1;
        else          run_cnt <= run_cnt + CNT_W'(1);
      end
      if (edge_seen && !(&edge_count))
        edge_count <= edge_count + EDGE_CNT_W'(1);
    end
  end

endmodule
